// File: rtl/cpu_pkg.sv
// Shared types and constants for the CPU pipeline stages.
package cpu_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    // Bit positions inside the M control bundle {MemRead, MemWrite, ByteOp}
    localparam int M_READ  = 2;
    localparam int M_WRITE = 1;
    localparam int M_BYTE  = 0;

    // Bit positions inside the WB control bundle {RegWrite, MemToReg}
    localparam int WB_REGWRITE = 1;
    localparam int WB_MEMTOREG = 0;

    localparam int TIMEOUT_DEFAULT = 255;

endpackage

// File: rtl/byte_lane_unit.sv
// Byte-lane steering: load lane extraction, store mask and data replication.
module byte_lane_unit (
    input  logic [2:0]  lane,
    input  logic        byte_op,
    input  logic [63:0] store_data,
    input  logic [63:0] rdata,
    output logic [63:0] load_data,
    output logic [63:0] wdata,
    output logic [7:0]  wmask
);

    always_comb begin
        load_data = rdata;
        wdata     = store_data;
        wmask     = 8'hFF;
        if (byte_op) begin
            load_data = {56'd0, rdata[{lane, 3'b000} +: 8]};
            wdata     = {8{store_data[7:0]}};
            wmask     = 8'h01 << lane;
        end
    end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: holds the pipe while a data-memory access completes,
// aborts misaligned or unanswered accesses with a one-cycle fault pulse.
module mem_stage
    import cpu_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_in,
    input  logic [63:0] ALUresult,
    input  logic [63:0] store_data,
    input  logic [4:0]  Rd,
    input  logic [1:0]  WB,
    input  logic [2:0]  M,
    output logic        mem_req,
    output logic        mem_we,
    output logic [63:0] mem_addr,
    output logic [63:0] mem_wdata,
    output logic [7:0]  mem_wmask,
    input  logic [63:0] mem_rdata,
    input  logic        mem_ack,
    output logic [63:0] Mem,
    output logic [63:0] ALUresult_out,
    output logic [4:0]  Rd_out,
    output logic [1:0]  WB_out,
    output logic        wb_enable,
    output logic        stall,
    output logic        fault
);

    localparam logic [7:0] TMO = 8'(TIMEOUT);

    state_t      state, state_nx;
    logic [63:0] addr_q, data_q;
    logic [4:0]  rd_q;
    logic [1:0]  wb_q;
    logic [2:0]  m_q;
    logic [7:0]  cnt_q;

    logic        is_mem, misaligned, accept, timed_out;
    logic [63:0] load_data, lane_wdata;
    logic [7:0]  lane_wmask;

    assign is_mem     = valid_in & (M[M_READ] | M[M_WRITE]);
    assign misaligned = ~M[M_BYTE] & (ALUresult[2:0] != 3'd0);
    assign accept     = ~rst & (state == IDLE) & is_mem & ~misaligned;
    assign timed_out  = (state == ACCESS) & ~mem_ack & (cnt_q == TMO);

    byte_lane_unit u_lane (
        .lane       (addr_q[2:0]),
        .byte_op    (m_q[M_BYTE]),
        .store_data (data_q),
        .rdata      (mem_rdata),
        .load_data  (load_data),
        .wdata      (lane_wdata),
        .wmask      (lane_wmask)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            addr_q <= '0;
            data_q <= '0;
            rd_q   <= '0;
            wb_q   <= '0;
            m_q    <= '0;
            cnt_q  <= '0;
        end else begin
            state <= state_nx;
            if (accept) begin
                addr_q <= ALUresult;
                data_q <= store_data;
                rd_q   <= Rd;
                wb_q   <= WB;
                m_q    <= M;
                cnt_q  <= '0;
            end else if (state == ACCESS && !mem_ack && !timed_out) begin
                cnt_q <= cnt_q + 8'd1;
            end
        end
    end

    always_comb begin
        state_nx      = state;
        mem_req       = 1'b0;
        mem_we        = 1'b0;
        mem_addr      = '0;
        mem_wdata     = '0;
        mem_wmask     = '0;
        Mem           = '0;
        ALUresult_out = '0;
        Rd_out        = '0;
        WB_out        = '0;
        wb_enable     = 1'b0;
        stall         = 1'b0;
        fault         = 1'b0;
        if (rst) begin
            state_nx = IDLE;
        end else begin
            unique case (state)
                IDLE: begin
                    if (!valid_in) begin
                        wb_enable = 1'b1;
                    end else if (!is_mem) begin
                        ALUresult_out = ALUresult;
                        Rd_out        = Rd;
                        WB_out        = WB;
                        wb_enable     = 1'b1;
                    end else if (misaligned) begin
                        ALUresult_out = ALUresult;
                        Rd_out        = Rd;
                        wb_enable     = 1'b1;
                        fault         = 1'b1;
                    end else begin
                        stall    = 1'b1;
                        state_nx = ACCESS;
                    end
                end
                ACCESS: begin
                    mem_req   = 1'b1;
                    mem_we    = m_q[M_WRITE];
                    mem_addr  = {addr_q[63:3], 3'b000};
                    mem_wdata = lane_wdata;
                    mem_wmask = lane_wmask;
                    ALUresult_out = addr_q;
                    Rd_out        = rd_q;
                    if (mem_ack) begin
                        // A write wins over a simultaneous read request
                        Mem       = m_q[M_WRITE] ? 64'd0 : load_data;
                        WB_out    = wb_q;
                        wb_enable = 1'b1;
                        state_nx  = IDLE;
                    end else if (timed_out) begin
                        wb_enable = 1'b1;
                        fault     = 1'b1;
                        state_nx  = IDLE;
                    end else begin
                        stall = 1'b1;
                    end
                end
                default: state_nx = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: driver queues expected writebacks,
// monitor pops and compares whenever the stage releases an op.
module tb_mem_stage;
    import cpu_pkg::*;

    localparam int TMO = 255;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_in;
    logic [63:0] ALUresult, store_data;
    logic [4:0]  Rd;
    logic [1:0]  WB;
    logic [2:0]  M;
    logic        mem_req, mem_we;
    logic [63:0] mem_addr, mem_wdata;
    logic [7:0]  mem_wmask;
    logic [63:0] mem_rdata;
    logic        mem_ack;
    logic [63:0] Mem, ALUresult_out;
    logic [4:0]  Rd_out;
    logic [1:0]  WB_out;
    logic        wb_enable, stall, fault;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [63:0] mem;
        logic [63:0] alu;
        logic [4:0]  rd;
        logic [1:0]  wb;
        logic        fault;
    } exp_t;

    exp_t q[$];

    mem_stage #(.TIMEOUT(TMO)) dut (
        .clk           (clk),
        .rst           (rst),
        .valid_in      (valid_in),
        .ALUresult     (ALUresult),
        .store_data    (store_data),
        .Rd            (Rd),
        .WB            (WB),
        .M             (M),
        .mem_req       (mem_req),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_wmask     (mem_wmask),
        .mem_rdata     (mem_rdata),
        .mem_ack       (mem_ack),
        .Mem           (Mem),
        .ALUresult_out (ALUresult_out),
        .Rd_out        (Rd_out),
        .WB_out        (WB_out),
        .wb_enable     (wb_enable),
        .stall         (stall),
        .fault         (fault)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && valid_in && wb_enable) begin
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_out: got release want none");
            end else begin
                exp_t e;
                e = q.pop_front();
                check("sb_fault", 64'(fault), 64'(e.fault));
                check("sb_wb", 64'(WB_out), 64'(e.wb));
                if (!e.fault) begin
                    check("sb_alu", ALUresult_out, e.alu);
                    check("sb_rd", 64'(Rd_out), 64'(e.rd));
                    check("sb_mem", Mem, e.mem);
                end
            end
        end
    end

    task automatic run_op(
        input string       tag,
        input logic [63:0] alu,
        input logic [63:0] sd,
        input logic [4:0]  r,
        input logic [1:0]  w,
        input logic [2:0]  m,
        input int          ack_at,
        input logic [63:0] rdata,
        input int          exp_stall,
        input logic        e_fault,
        input logic [63:0] e_mem,
        input logic [7:0]  e_mask,
        input logic [63:0] e_wdata
    );
        exp_t e;
        int stalls, reqs, cyc;
        bit done;
        logic [63:0] e_addr;
        e_addr = {alu[63:3], 3'b000};
        @(posedge clk);
        #1;
        valid_in   = 1'b1;
        ALUresult  = alu;
        store_data = sd;
        Rd         = r;
        WB         = w;
        M          = m;
        mem_ack    = 1'b0;
        mem_rdata  = rdata;
        e.mem   = e_mem;
        e.alu   = alu;
        e.rd    = r;
        e.wb    = e_fault ? 2'b00 : w;
        e.fault = e_fault;
        q.push_back(e);
        stalls = 0;
        reqs   = 0;
        cyc    = 0;
        done   = 1'b0;
        for (int i = 0; i < 600 && !done; i++) begin
            @(negedge clk);
            if (stall) stalls++;
            if (mem_req) begin
                reqs++;
                check({tag, "_addr"}, mem_addr, e_addr);
                check({tag, "_we"}, 64'(mem_we), 64'(m[M_WRITE]));
                if (reqs == 1 && m[M_WRITE]) begin
                    check({tag, "_wmask"}, 64'(mem_wmask), 64'(e_mask));
                    check({tag, "_wdata"}, mem_wdata, e_wdata);
                end
            end
            if (!stall) begin
                done = 1'b1;
            end else begin
                @(posedge clk);
                #1;
                cyc++;
                mem_ack = (cyc == ack_at);
            end
        end
        if (!done) begin
            total++;
            bad++;
            $display("FAIL %s_bound: got stuck want release", tag);
        end
        check({tag, "_stalls"}, 64'(stalls), 64'(exp_stall));
        check({tag, "_reqs"}, 64'(reqs), 64'(exp_stall));
        @(posedge clk);
        #1;
        valid_in = 1'b0;
        mem_ack  = 1'b0;
    endtask

    initial begin
        rst        = 1'b1;
        valid_in   = 1'b1;
        ALUresult  = 64'h108;
        store_data = 64'h0;
        Rd         = 5'd3;
        WB         = 2'b11;
        M          = 3'b100;
        mem_rdata  = 64'h0;
        mem_ack    = 1'b0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_req", 64'(mem_req), 64'd0);
        check("rst_wben", 64'(wb_enable), 64'd0);
        check("rst_stall", 64'(stall), 64'd0);
        check("rst_fault", 64'(fault), 64'd0);
        check("rst_wb", 64'(WB_out), 64'd0);
        check("rst_mem", Mem, 64'd0);
        check("rst_alu", ALUresult_out, 64'd0);
        check("rst_rd", 64'(Rd_out), 64'd0);
        @(posedge clk);
        #1;
        rst      = 1'b0;
        valid_in = 1'b0;

        @(negedge clk);
        check("idle_wben", 64'(wb_enable), 64'd1);
        check("idle_wb", 64'(WB_out), 64'd0);
        check("idle_stall", 64'(stall), 64'd0);

        run_op("add", 64'h1234, 64'h0, 5'd5, 2'b10, 3'b000,
               0, 64'h0, 0, 1'b0, 64'h0, 8'h00, 64'h0);
        run_op("add2", 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 5'd31, 2'b10,
               3'b000, 0, 64'h0, 0, 1'b0, 64'h0, 8'h00, 64'h0);
        run_op("ldur", 64'h100, 64'h0, 5'd3, 2'b11, 3'b100,
               3, 64'hDEAD_BEEF_CAFE_F00D, 3, 1'b0,
               64'hDEAD_BEEF_CAFE_F00D, 8'h00, 64'h0);
        run_op("sturb", 64'h105, 64'hAB, 5'd0, 2'b00, 3'b011,
               1, 64'h0, 1, 1'b0, 64'h0, 8'h20, 64'hABAB_ABAB_ABAB_ABAB);
        run_op("sturb7", 64'h107, 64'h1234_5678_9ABC_DE5A, 5'd0, 2'b00,
               3'b011, 2, 64'h0, 2, 1'b0, 64'h0, 8'h80,
               64'h5A5A_5A5A_5A5A_5A5A);
        run_op("stur", 64'h408, 64'h1122_3344_5566_7788, 5'd0, 2'b00,
               3'b010, 1, 64'hFFFF, 1, 1'b0, 64'h0, 8'hFF,
               64'h1122_3344_5566_7788);
        run_op("rdwr", 64'h500, 64'h0F0F_0F0F_0F0F_0F0F, 5'd0, 2'b00,
               3'b110, 1, 64'hFFFF, 1, 1'b0, 64'h0, 8'hFF,
               64'h0F0F_0F0F_0F0F_0F0F);

        @(posedge clk);
        #1;
        mem_ack   = 1'b1;
        mem_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
        @(negedge clk);
        check("idleack_req", 64'(mem_req), 64'd0);
        check("idleack_stall", 64'(stall), 64'd0);
        check("idleack_wb", 64'(WB_out), 64'd0);

        run_op("ldurb", 64'h203, 64'h0, 5'd7, 2'b11, 3'b101,
               2, 64'h0000_0000_7F00_0000, 2, 1'b0, 64'h7F, 8'h00, 64'h0);
        run_op("misld", 64'h104, 64'h0, 5'd2, 2'b11, 3'b100,
               1, 64'h0, 0, 1'b1, 64'h0, 8'h00, 64'h0);
        run_op("misst", 64'h10A, 64'h0, 5'd0, 2'b00, 3'b010,
               1, 64'h0, 0, 1'b1, 64'h0, 8'h00, 64'h0);
        run_op("tmo", 64'h300, 64'h0, 5'd4, 2'b11, 3'b100,
               0, 64'h0, TMO + 1, 1'b1, 64'h0, 8'h00, 64'h0);
        run_op("tmoack", 64'h308, 64'h0, 5'd6, 2'b11, 3'b100,
               TMO + 1, 64'h0123_4567_89AB_CDEF, TMO + 1, 1'b0,
               64'h0123_4567_89AB_CDEF, 8'h00, 64'h0);

        @(posedge clk);
        #1;
        valid_in  = 1'b1;
        ALUresult = 64'h600;
        Rd        = 5'd9;
        WB        = 2'b11;
        M         = 3'b100;
        mem_ack   = 1'b0;
        @(negedge clk);
        check("rsta_stall0", 64'(stall), 64'd1);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("rsta_req1", 64'(mem_req), 64'd1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        check("rsta_req", 64'(mem_req), 64'd0);
        check("rsta_fault", 64'(fault), 64'd0);
        check("rsta_stall", 64'(stall), 64'd0);
        check("rsta_wben", 64'(wb_enable), 64'd0);
        @(posedge clk);
        #1;
        rst      = 1'b0;
        valid_in = 1'b0;
        @(negedge clk);
        check("rsta_idle_req", 64'(mem_req), 64'd0);
        check("rsta_idle_stall", 64'(stall), 64'd0);
        check("rsta_idle_wben", 64'(wb_enable), 64'd1);
        check("rsta_idle_fault", 64'(fault), 64'd0);

        repeat (2) @(posedge clk);
        check("queue_empty", 64'(q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameters SHALL be: TIMEOUT, 255, max wait cycles for mem_ack before abort.
REQ-002 One clock and one reset SHALL be used; reset is synchronous and active-high; ports: clk in 1 rising-edge clock; rst in 1 synchronous active-high reset.
REQ-003 Upstream ports SHALL be: valid_in in 1 EX/MEM holds a live op; ALUresult in 64 address / pass-through result; store_data in 64 STUR/STURB data; Rd in 5 dest reg; WB in 2 {RegWrite, MemToReg}; M in 3 {MemRead, MemWrite, ByteOp}.
REQ-004 Memory ports SHALL be: mem_req out 1; mem_we out 1; mem_addr out 64; mem_wdata out 64; mem_wmask out 8 byte enables; mem_rdata in 64; mem_ack in 1 one-cycle completion.
REQ-005 Downstream ports SHALL be: Mem out 64 load data; ALUresult_out out 64; Rd_out out 5; WB_out out 2; wb_enable out 1 MEM/WB enable; stall out 1 hold PC/IF/ID/EX/MEM registers; fault out 1 one-cycle abort pulse.

Function
REQ-006 FSM SHALL have states IDLE and ACCESS only.
REQ-007 IDLE, valid_in=0: wb_enable=1, WB_out=00 (bubble), stall=0, mem_req=0.
REQ-008 IDLE, valid_in=1, MemRead=MemWrite=0: outputs SHALL pass ALUresult/Rd/WB through combinationally, Mem=0, wb_enable=1, stall=0; zero added latency.
REQ-009 IDLE, valid_in=1, MemRead or MemWrite set: latch ALUresult, store_data, Rd, WB, M; stall=1, wb_enable=0; next state ACCESS; wait counter cleared.
REQ-010 MemRead and MemWrite both set SHALL be treated as MemWrite.
REQ-011 Misaligned 64-bit op (ByteOp=0, ALUresult[2:0]!=0) SHALL not enter ACCESS: fault=1, WB_out=00, wb_enable=1, stall=0, no mem_req, same cycle.
REQ-012 ACCESS: mem_req=1, mem_we=latched MemWrite, mem_addr={latched addr[63:3],3'b000}, held stable until ack or abort.
REQ-013 Write mask SHALL be 8'hFF for 64-bit, 8'h01<<addr[2:0] for byte; byte wdata SHALL be store_data[7:0] replicated to all 8 lanes.
REQ-014 ACCESS with mem_ack=1: Mem = mem_rdata (64-bit) or zero-extended byte lane addr[2:0] (LDURB); outputs from latched values; wb_enable=1, stall=0; next state IDLE.
REQ-015 Stores SHALL present WB_out from latched WB (RegWrite expected 0); Mem=0.
REQ-016 Wait counter (8-bit) SHALL increment each ACCESS cycle without ack; at TIMEOUT without ack: abort, fault=1, WB_out=00, wb_enable=1, stall=0, next IDLE.
REQ-017 Ack on the TIMEOUT cycle SHALL win (normal completion, no fault).
REQ-018 mem_ack in IDLE SHALL be ignored.
REQ-019 stall SHALL be 1 for every ACCESS cycle except the completion/abort cycle.

Reset
REQ-020 On rst: state=IDLE, latches=0, counter=0; while rst=1 mem_req=0, wb_enable=0, stall=0, fault=0, WB_out=00, Mem=0, ALUresult_out=0, Rd_out=0.
REQ-021 rst during ACCESS SHALL abort the access with no fault pulse; mem_req=0 from the reset cycle on.

Structure
REQ-022 cpu_pkg SHALL hold the state enum, M/WB bit-position constants and TIMEOUT default.
REQ-023 Byte-lane load extraction and store mask/replication SHALL live in sub-module byte_lane_unit (combinational); all state in mem_stage.

Verification
REQ-024 ADD pass-through: valid_in=1, M=000, ALUresult=0x1234, Rd=5, WB=10 -> same cycle ALUresult_out=0x1234, Rd_out=5, wb_enable=1, stall=0.
REQ-025 LDUR addr 0x100, ack after 3 cycles with rdata 0xDEADBEEF_CAFEF00D -> stall=1 for 3 cycles, ack cycle Mem=0xDEADBEEFCAFEF00D, wb_enable=1.
REQ-026 STURB addr 0x105, store_data=0xAB -> mem_wmask=8'h20, mem_wdata=0xABAB…AB, mem_addr=0x100, mem_we=1.
REQ-027 LDURB addr 0x203, rdata 0x0000_0000_7F00_0000 -> Mem=0x7F.
REQ-028 LDUR addr 0x104 -> fault=1 same cycle, WB_out=00, mem_req never asserted; no ack for TIMEOUT cycles -> fault pulse, stall drops.
REQ-029 rst asserted in 2nd ACCESS cycle -> mem_req=0 from that cycle, IDLE after edge, fault=0.
